// File: rtl/pcie_tx_arbiter.sv
`timescale 1ns/1ps
// pcie_tx_arbiter
// Packet-level round-robin arbiter sharing the 7-series PCIe core transmit
// AXI-Stream port between two TLP sources (p0: cfg/control, p1: memory
// requests). Whole packets are granted. New grants are withheld while the
// link is down or tx_buf_av < BUF_AV_MIN. A packet that has started always
// completes. Data path is combinational pass-through of the owning port.
//
// Ports:
//   user_clk, user_reset       clock, synchronous active-high reset
//   user_lnk_up, tx_buf_av     grant gating from the core
//   tx_err_drop                core drop pulse, counted into drop_cnt
//   p0_*/p1_*                  source AXI-Stream slaves
//   s_axis_tx_*                AXI-Stream master to the core
//   grant                      one-hot current owner, 00 when idle
//   p0_pkt_cnt/p1_pkt_cnt      completed packets per port (wrap)
//   drop_cnt                   drop pulses (saturating)
module pcie_tx_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH/8,
  parameter int BUF_AV_MIN   = 2
) (
  input  logic                    user_clk,
  input  logic                    user_reset,
  input  logic                    user_lnk_up,
  input  logic [5:0]              tx_buf_av,
  input  logic                    tx_err_drop,
  input  logic [C_DATA_WIDTH-1:0] p0_tdata,
  input  logic [KEEP_WIDTH-1:0]   p0_tkeep,
  input  logic [3:0]              p0_tuser,
  input  logic                    p0_tlast,
  input  logic                    p0_tvalid,
  output logic                    p0_tready,
  input  logic [C_DATA_WIDTH-1:0] p1_tdata,
  input  logic [KEEP_WIDTH-1:0]   p1_tkeep,
  input  logic [3:0]              p1_tuser,
  input  logic                    p1_tlast,
  input  logic                    p1_tvalid,
  output logic                    p1_tready,
  output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
  output logic [3:0]              s_axis_tx_tuser,
  output logic                    s_axis_tx_tlast,
  output logic                    s_axis_tx_tvalid,
  input  logic                    s_axis_tx_tready,
  output logic [1:0]              grant,
  output logic [15:0]             p0_pkt_cnt,
  output logic [15:0]             p1_pkt_cnt,
  output logic [15:0]             drop_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // 1: port 1 was granted most recently
  logic [1:0]       done;             // tlast beat transferred, per port
  logic [1:0][15:0] pkt_cnt_q;
  logic [15:0]      drop_cnt_q;
  logic             can_start;

  assign can_start = user_lnk_up && (tx_buf_av >= 6'(BUF_AV_MIN));

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    done             = '0;
    p0_tready        = 1'b0;
    p1_tready        = 1'b0;
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tuser  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start) begin
          // port 0 wins unless port 1 is also waiting and port 0 went last
          if (p0_tvalid && (!p1_tvalid || last_q)) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else if (p1_tvalid) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end
      end
      GNT0: begin
        s_axis_tx_tdata  = p0_tdata;
        s_axis_tx_tkeep  = p0_tkeep;
        s_axis_tx_tuser  = p0_tuser;
        s_axis_tx_tlast  = p0_tlast;
        s_axis_tx_tvalid = p0_tvalid;
        p0_tready        = s_axis_tx_tready;
        done[0]          = p0_tvalid && s_axis_tx_tready && p0_tlast;
        if (done[0]) state_d = IDLE;
      end
      GNT1: begin
        s_axis_tx_tdata  = p1_tdata;
        s_axis_tx_tkeep  = p1_tkeep;
        s_axis_tx_tuser  = p1_tuser;
        s_axis_tx_tlast  = p1_tlast;
        s_axis_tx_tvalid = p1_tvalid;
        p1_tready        = s_axis_tx_tready;
        done[1]          = p1_tvalid && s_axis_tx_tready && p1_tlast;
        if (done[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      for (int n = 0; n < 2; n++)
        if (done[n]) pkt_cnt_q[n] <= pkt_cnt_q[n] + 16'd1;
      if (tx_err_drop && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign grant      = {state_q == GNT1, state_q == GNT0};
  assign p0_pkt_cnt = pkt_cnt_q[0];
  assign p1_pkt_cnt = pkt_cnt_q[1];
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
`timescale 1ns/1ps
module tb_pcie_tx_arbiter;
  localparam int DW = 64;
  localparam int KW = DW/8;

  logic          user_clk = 1'b0;
  logic          user_reset;
  logic          user_lnk_up;
  logic [5:0]    tx_buf_av;
  logic          tx_err_drop;
  logic [DW-1:0] p0_tdata, p1_tdata;
  logic [KW-1:0] p0_tkeep, p1_tkeep;
  logic [3:0]    p0_tuser, p1_tuser;
  logic          p0_tlast, p1_tlast, p0_tvalid, p1_tvalid, p0_tready, p1_tready;
  logic [DW-1:0] s_axis_tx_tdata;
  logic [KW-1:0] s_axis_tx_tkeep;
  logic [3:0]    s_axis_tx_tuser;
  logic          s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready;
  logic [1:0]    grant;
  logic [15:0]   p0_pkt_cnt, p1_pkt_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  pcie_tx_arbiter #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .BUF_AV_MIN(2)) dut (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .tx_buf_av(tx_buf_av), .tx_err_drop(tx_err_drop),
    .p0_tdata(p0_tdata), .p0_tkeep(p0_tkeep), .p0_tuser(p0_tuser),
    .p0_tlast(p0_tlast), .p0_tvalid(p0_tvalid), .p0_tready(p0_tready),
    .p1_tdata(p1_tdata), .p1_tkeep(p1_tkeep), .p1_tuser(p1_tuser),
    .p1_tlast(p1_tlast), .p1_tvalid(p1_tvalid), .p1_tready(p1_tready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
    .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
    .grant(grant), .p0_pkt_cnt(p0_pkt_cnt), .p1_pkt_cnt(p1_pkt_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs change 1ns after the active edge; outputs are sampled 1ns later
  task automatic nxt();
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle_inputs();
    user_lnk_up = 1'b0; tx_buf_av = 6'd0; tx_err_drop = 1'b0;
    p0_tdata = '0; p0_tkeep = '0; p0_tuser = '0; p0_tlast = 1'b0; p0_tvalid = 1'b0;
    p1_tdata = '0; p1_tkeep = '0; p1_tuser = '0; p1_tlast = 1'b0; p1_tvalid = 1'b0;
    s_axis_tx_tready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    user_reset = 1'b1;
    nxt(); nxt();
    user_reset = 1'b0;
  endtask

  typedef struct {
    logic       lnk;
    logic [5:0] bav;
    logic       p0v, p0l, p1v, p1l, rdy;
    logic [1:0] g;
    logic       p0r, p1r, tv;
  } vec_t;

  vec_t vt[16];

  // reference model state for the random phase
  int own, lastp, c0, c1, dc;

  initial begin
    // ---------------- table of cycle vectors ----------------
    //          lnk   bav    p0v   p0l   p1v   p1l   rdy   grant  p0r   p1r   tv
    vt[0]  = '{1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 6'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 6'd2,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1};
    vt[15] = '{1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};

    user_reset = 1'b1;
    idle_inputs();
    do_reset();

    // reset state
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    chk("rst_tdata", s_axis_tx_tdata, 64'd0);
    chk("rst_treadys", 64'({p1_tready, p0_tready}), 64'd0);
    chk("rst_cnts", {16'd0, p0_pkt_cnt, p1_pkt_cnt, drop_cnt}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      logic [63:0] ed;
      logic        el;
      user_lnk_up = vt[i].lnk; tx_buf_av = vt[i].bav;
      p0_tvalid = vt[i].p0v; p0_tlast = vt[i].p0l; p1_tvalid = vt[i].p1v; p1_tlast = vt[i].p1l;
      s_axis_tx_tready = vt[i].rdy;
      p0_tdata = {32'hA0A0_0000, 32'(i)}; p1_tdata = {32'hB1B1_0000, 32'(i)};
      p0_tkeep = 8'h0F; p1_tkeep = 8'hF0; p0_tuser = 4'h3; p1_tuser = 4'hC;
      #1;
      ed = (vt[i].g == 2'b01) ? p0_tdata : (vt[i].g == 2'b10) ? p1_tdata : 64'd0;
      el = (vt[i].g == 2'b01) ? vt[i].p0l : (vt[i].g == 2'b10) ? vt[i].p1l : 1'b0;
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vt[i].g));
      chk($sformatf("vec%0d_p0r", i), 64'(p0_tready), 64'(vt[i].p0r));
      chk($sformatf("vec%0d_p1r", i), 64'(p1_tready), 64'(vt[i].p1r));
      chk($sformatf("vec%0d_tvalid", i), 64'(s_axis_tx_tvalid), 64'(vt[i].tv));
      chk($sformatf("vec%0d_tdata", i), s_axis_tx_tdata, ed);
      chk($sformatf("vec%0d_tlast", i), 64'(s_axis_tx_tlast), 64'(el));
      nxt();
    end
    chk("tbl_p0cnt", 64'(p0_pkt_cnt), 64'd2);
    chk("tbl_p1cnt", 64'(p1_pkt_cnt), 64'd1);

    // ---------------- mid-packet link loss / backpressure ----------------
    begin
      logic [63:0] pkt[4];
      int idx;
      for (int k = 0; k < 4; k++) pkt[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
      idle_inputs();
      user_lnk_up = 1'b1; tx_buf_av = 6'd10; p0_tvalid = 1'b1; p0_tdata = pkt[0];
      #1;
      chk("mid_req_grant", 64'(grant), 64'd0);
      nxt();
      user_lnk_up = 1'b0; tx_buf_av = 6'd0;
      idx = 0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
        s_axis_tx_tready = c[0];
        p0_tdata = pkt[idx]; p0_tlast = (idx == 3);
        #1;
        chk("mid_grant", 64'(grant), 64'd1);
        if (s_axis_tx_tvalid && s_axis_tx_tready) begin
          chk("mid_data", s_axis_tx_tdata, pkt[idx]);
          idx++;
        end
        nxt();
      end
      chk("mid_beats", 64'(idx), 64'd4);
      p0_tlast = 1'b0; s_axis_tx_tready = 1'b1;
      for (int c = 0; c < 5; c++) begin
        #1;
        chk("mid_no_regrant", 64'(grant), 64'd0);
        nxt();
      end
      chk("mid_p0cnt", 64'(p0_pkt_cnt), 64'd3);
    end

    // ---------------- reset in beat 2 of a 4-beat packet ----------------
    idle_inputs();
    tx_err_drop = 1'b1;
    nxt(); nxt();
    tx_err_drop = 1'b0;
    #1;
    chk("pre_rst_drop", 64'(drop_cnt), 64'd2);
    user_lnk_up = 1'b1; tx_buf_av = 6'd10; s_axis_tx_tready = 1'b1; p0_tvalid = 1'b1;
    nxt();                    // request seen
    nxt();                    // beat 1 transferred
    user_reset = 1'b1;        // beat 2
    nxt();
    user_reset = 1'b0; p0_tvalid = 1'b0;
    #1;
    chk("rst_mid_grant", 64'(grant), 64'd0);
    chk("rst_mid_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
    chk("rst_mid_cnts", {16'd0, p0_pkt_cnt, p1_pkt_cnt, drop_cnt}, 64'd0);
    p0_tvalid = 1'b1; p1_tvalid = 1'b1;
    nxt();
    chk("rst_after_grant", 64'(grant), 64'd1);

    // ---------------- alternation, both ports always valid ----------------
    do_reset();
    begin
      int expg[12] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
      int b0, b1;
      b0 = 0; b1 = 0;
      user_lnk_up = 1'b1; tx_buf_av = 6'd10; s_axis_tx_tready = 1'b1;
      p0_tvalid = 1'b1; p1_tvalid = 1'b1;
      for (int k = 0; k < 12; k++) begin
        p0_tlast = (b0 == 1); p1_tlast = (b1 == 1);
        #1;
        chk($sformatf("alt%0d_grant", k), 64'(grant), 64'(expg[k]));
        if (expg[k] == 1) b0 = (b0 + 1) % 2;
        if (expg[k] == 2) b1 = (b1 + 1) % 2;
        nxt();
      end
      p0_tvalid = 1'b0; p1_tvalid = 1'b0;
      #1;
      chk("alt_p0cnt", 64'(p0_pkt_cnt), 64'd2);
      chk("alt_p1cnt", 64'(p1_pkt_cnt), 64'd2);
    end

    // ---------------- randomized against reference model ----------------
    do_reset();
    own = -1; lastp = 1; c0 = 0; c1 = 0; dc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] ed; logic [7:0] ek; logic [3:0] eu; logic el, ev, r0, r1;
      logic v[2], l[2];
      user_lnk_up = ($urandom_range(0, 3) != 0);
      tx_buf_av = 6'($urandom_range(0, 5));
      tx_err_drop = ($urandom_range(0, 7) == 0);
      p0_tvalid = $urandom_range(0, 1) == 1; p1_tvalid = $urandom_range(0, 1) == 1;
      p0_tlast = ($urandom_range(0, 2) == 0); p1_tlast = ($urandom_range(0, 2) == 0);
      s_axis_tx_tready = ($urandom_range(0, 3) != 0);
      p0_tdata = {$urandom, $urandom}; p1_tdata = {$urandom, $urandom};
      p0_tkeep = 8'($urandom); p1_tkeep = 8'($urandom);
      p0_tuser = 4'($urandom); p1_tuser = 4'($urandom);
      v[0] = p0_tvalid; v[1] = p1_tvalid; l[0] = p0_tlast; l[1] = p1_tlast;
      ed = 64'd0; ek = 8'd0; eu = 4'd0; el = 1'b0; ev = 1'b0; r0 = 1'b0; r1 = 1'b0;
      if (own == 0) begin
        ed = p0_tdata; ek = p0_tkeep; eu = p0_tuser; el = p0_tlast; ev = p0_tvalid; r0 = s_axis_tx_tready;
      end else if (own == 1) begin
        ed = p1_tdata; ek = p1_tkeep; eu = p1_tuser; el = p1_tlast; ev = p1_tvalid; r1 = s_axis_tx_tready;
      end
      #1;
      chk("rnd_grant", 64'(grant), (own < 0) ? 64'd0 : 64'(1 << own));
      chk("rnd_tvalid", 64'(s_axis_tx_tvalid), 64'(ev));
      chk("rnd_tdata", s_axis_tx_tdata, ed);
      chk("rnd_tkeep", 64'(s_axis_tx_tkeep), 64'(ek));
      chk("rnd_tuser", 64'(s_axis_tx_tuser), 64'(eu));
      chk("rnd_tlast", 64'(s_axis_tx_tlast), 64'(el));
      chk("rnd_treadys", 64'({p1_tready, p0_tready}), 64'({r1, r0}));
      chk("rnd_cnts", {16'd0, p0_pkt_cnt, p1_pkt_cnt, drop_cnt},
          {16'd0, 16'(c0), 16'(c1), 16'(dc)});
      // advance model to next cycle
      if (tx_err_drop && dc < 65535) dc++;
      if (own >= 0) begin
        if (v[own] && s_axis_tx_tready && l[own]) begin
          if (own == 0) c0 = (c0 + 1) % 65536; else c1 = (c1 + 1) % 65536;
          own = -1;
        end
      end else if (user_lnk_up && tx_buf_av >= 2 && (v[0] || v[1])) begin
        if (v[0] && v[1]) own = (lastp == 1) ? 0 : 1;
        else own = v[0] ? 0 : 1;
        lastp = own;
      end
      nxt();
    end

    // ---------------- drop saturation with concurrent p1 packets ----------------
    do_reset();
    user_lnk_up = 1'b1; tx_buf_av = 6'd10; s_axis_tx_tready = 1'b1;
    p1_tvalid = 1'b1; p1_tlast = 1'b1; tx_err_drop = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      nxt();
      if (i == 65533) chk("sat_drop_fffe", 64'(drop_cnt), 64'hFFFE);
    end
    tx_err_drop = 1'b0; p1_tvalid = 1'b0;
    #1;
    chk("sat_drop", 64'(drop_cnt), 64'hFFFF);
    chk("sat_p1cnt", 64'(p1_pkt_cnt), 64'd32768);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level arbiter that shares the PCIe hard-block transmit AXI-Stream port (s_axis_tx_*) between two TLP sources: port 0 (configuration/control TLP engine) and port 1 (memory-request TLP engine of the RISC-V SoC). It sits between the SoC TLP generators and the 7-series PCIe core, in the user_clk domain. It grants whole packets only, round-robin between ports. It withholds new grants while the link is down or the core reports too few transmit buffers. It also keeps per-port packet counters and a drop counter for debug.

## Interface

Parameters:
- C_DATA_WIDTH, 64, TX data width in bits.
- KEEP_WIDTH, C_DATA_WIDTH/8, byte-enable width.
- BUF_AV_MIN, 2, minimum tx_buf_av value required to start a new packet.

Ports:
- user_clk  in  1  core user clock; the only clock.
- user_reset  in  1  synchronous, active-high reset.
- user_lnk_up  in  1  link-up from the core; gates new grants.
- tx_buf_av  in  6  available transmit buffers, from the core.
- tx_err_drop  in  1  one-cycle pulse from the core when it drops a TLP.
- p0_tdata / p1_tdata  in  C_DATA_WIDTH  source data.
- p0_tkeep / p1_tkeep  in  KEEP_WIDTH  source byte enables.
- p0_tuser / p1_tuser  in  4  source tuser (passed through).
- p0_tlast / p1_tlast  in  1  end of packet.
- p0_tvalid / p1_tvalid  in  1  source valid.
- p0_tready / p1_tready  out  1  source ready.
- s_axis_tx_tdata  out  C_DATA_WIDTH  to core.
- s_axis_tx_tkeep  out  KEEP_WIDTH  to core.
- s_axis_tx_tuser  out  4  to core.
- s_axis_tx_tlast  out  1  to core.
- s_axis_tx_tvalid  out  1  to core.
- s_axis_tx_tready  in  1  from core.
- grant  out  2  one-hot current owner; 00 when idle.
- p0_pkt_cnt / p1_pkt_cnt  out  16  packets completed per port; wraps.
- drop_cnt  out  16  count of tx_err_drop pulses; saturates at 0xFFFF.

## Operation

- States:
  - IDLE: no owner; all tready = 0; s_axis_tx_tvalid = 0.
  - GNT0: port 0 owns the core port.
  - GNT1: port 1 owns the core port.
- IDLE -> GNTn when all of the following hold:
  - user_lnk_up = 1;
  - tx_buf_av >= BUF_AV_MIN (unsigned 6-bit compare);
  - pn_tvalid = 1.
- If both ports are valid, the port not recorded in last_grant wins. last_grant updates on every IDLE -> GNTn transition.
- In GNTn, the datapath is combinational pass-through:
  - s_axis_tx_{tdata,tkeep,tuser,tlast,tvalid} = pn_*;
  - pn_tready = s_axis_tx_tready;
  - the other port's tready = 0.
- A beat transfers when s_axis_tx_tvalid & s_axis_tx_tready.
- On a transferred beat with tlast = 1:
  - GNTn -> IDLE;
  - pn_pkt_cnt increments by 1 (wraps 0xFFFF -> 0).
- Ownership is held for the whole packet:
  - user_lnk_up falling or tx_buf_av dropping mid-packet never aborts a packet;
  - the packet completes under core backpressure.
- Source tvalid deasserting mid-packet holds the grant; s_axis_tx_tvalid follows it low.
- tx_err_drop pulses increment drop_cnt in any state, saturating at 0xFFFF.
- grant = {state==GNT1, state==GNT0}.

## Timing

- Reset values:
  - state = IDLE; grant = 00;
  - all tready = 0; s_axis_tx_tvalid = 0;
  - s_axis_tx_tdata/tkeep/tuser/tlast = 0 (data muxed to 0 when IDLE);
  - counters = 0;
  - last_grant = port 1, so port 0 wins the first contention.
- Arbitration latency: request seen in IDLE at cycle N -> grant and first beat presented at cycle N+1.
- Data latency through the block: 0 cycles (combinational).
- After each tlast beat there is exactly one IDLE cycle before any new grant, including back-to-back packets from the same port.
- user_reset asserted mid-packet:
  - next cycle is IDLE with all outputs at reset values;
  - the partial packet is abandoned; the core is reset by the same event.
- Simultaneous tlast transfer and tx_err_drop: both the packet counter and drop_cnt increment in that cycle.

## Test plan

- Single port, 3-beat packet on p0 with lnk_up = 1, tx_buf_av = 10, core tready = 1:
  - grant = 01 one cycle after p0_tvalid;
  - 3 beats pass unchanged;
  - IDLE the cycle after tlast;
  - p0_pkt_cnt = 1.
- Both ports continuously valid, 2-beat packets:
  - grants alternate 01, 10, 01, 10, one IDLE cycle between each;
  - after 4 packets, p0_pkt_cnt = 2 and p1_pkt_cnt = 2.
- tx_buf_av = 1 with p1_tvalid = 1:
  - no grant and p1_tready = 0;
  - raise tx_buf_av to 2 -> grant = 10 next cycle.
- Mid-packet: lnk_up low, tx_buf_av = 0, core tready toggling:
  - packet still completes with all beats intact and in order;
  - no beat duplicated or lost; no new grant afterwards while lnk_up = 0.
- user_reset in beat 2 of a 4-beat packet:
  - next cycle grant = 00, s_axis_tx_tvalid = 0, counters = 0;
  - the next p0 packet arbitrates normally.
- 65537 tx_err_drop pulses -> drop_cnt = 0xFFFF; 65536 p1 packets -> p1_pkt_cnt = 0.
